// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: command front end for an external 8-bit combinational ALU.
// Accepts commands over valid/ready, reads operands from a local register
// file, presents them to the ALU for one cycle, writes Y back and reports the
// result over a valid/ready result channel.
// Optional build macro: ALU_ISSUER_OVF_EN adds the res_ovf output.
module alu_cmd_issuer #(
  parameter int WIDTH = 8,
  parameter int NREG  = 4,
  localparam int AW   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [2:0]       cmd_op,
  input  logic [AW-1:0]    cmd_dst,
  input  logic [AW-1:0]    cmd_src_a,
  input  logic [AW-1:0]    cmd_src_b,
  input  logic             cmd_imm_en,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [2:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [AW-1:0]    res_dst,
  output logic             res_zero,
  output logic             busy
`ifdef ALU_ISSUER_OVF_EN
  ,
  output logic             res_ovf
`endif
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] regs [NREG];
  logic [AW-1:0]    dst_q;
  logic [WIDTH-1:0] b_sel;
  logic             accept;

`ifdef ALU_ISSUER_OVF_EN
  // Signed overflow of the ALU result; only add and sub can overflow.
  function automatic logic calc_ovf(input logic [2:0] op,
                                    input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b,
                                    input logic [WIDTH-1:0] y);
    logic ovf;
    ovf = 1'b0;
    if (op == OP_ADD)
      ovf = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
    else if (op == OP_SUB)
      ovf = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
    return ovf;
  endfunction
`endif

  // Handshake status comes straight from the state register; there is no
  // command buffer, so the block only listens while idle.
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // Operand B is either the immediate or a register read at accept time.
  always_comb begin
    b_sel = cmd_imm_en ? cmd_imm : regs[cmd_src_b];
  end

  // Main FSM: capture at accept, drive the ALU for one cycle, write back and
  // hold the result until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      dst_q      <= '0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_dst    <= '0;
      res_zero   <= 1'b0;
`ifdef ALU_ISSUER_OVF_EN
      res_ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (cmd_load) begin
              regs[cmd_dst] <= cmd_imm;
              res_data      <= cmd_imm;
              res_dst       <= cmd_dst;
              res_zero      <= (cmd_imm == '0);
              res_valid     <= 1'b1;
`ifdef ALU_ISSUER_OVF_EN
              res_ovf       <= 1'b0;
`endif
              state         <= REPORT;
            end else begin
              alu_opcode <= cmd_op;
              alu_a      <= regs[cmd_src_a];
              alu_b      <= b_sel;
              dst_q      <= cmd_dst;
              state      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          regs[dst_q] <= alu_y;
          res_data    <= alu_y;
          res_dst     <= dst_q;
          res_zero    <= (alu_y == '0);
          res_valid   <= 1'b1;
`ifdef ALU_ISSUER_OVF_EN
          res_ovf     <= calc_ovf(alu_opcode, alu_a, alu_b, alu_y);
`endif
          alu_opcode  <= '0;
          alu_a       <= '0;
          alu_b       <= '0;
          state       <= REPORT;
        end
        REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: directed self-checking bench for alu_cmd_issuer with a
// behavioural model of the external combinational ALU.
module tb_alu_cmd_issuer;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_load;
  logic [2:0] cmd_op;
  logic [1:0] cmd_dst;
  logic [1:0] cmd_src_a;
  logic [1:0] cmd_src_b;
  logic       cmd_imm_en;
  logic [7:0] cmd_imm;
  logic [2:0] alu_opcode;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_y;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [1:0] res_dst;
  logic       res_zero;
  logic       busy;
`ifdef ALU_ISSUER_OVF_EN
  logic       res_ovf;
`endif

  int checks = 0;
  int errors = 0;

  alu_cmd_issuer #(.WIDTH(8), .NREG(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_load   (cmd_load),
    .cmd_op     (cmd_op),
    .cmd_dst    (cmd_dst),
    .cmd_src_a  (cmd_src_a),
    .cmd_src_b  (cmd_src_b),
    .cmd_imm_en (cmd_imm_en),
    .cmd_imm    (cmd_imm),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_y      (alu_y),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_dst    (res_dst),
    .res_zero   (res_zero),
    .busy       (busy)
`ifdef ALU_ISSUER_OVF_EN
    ,
    .res_ovf    (res_ovf)
`endif
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU model: 8-bit combinational, results mod 256.
  always_comb begin
    case (alu_opcode)
      3'b000:  alu_y = alu_a + alu_b;
      3'b001:  alu_y = alu_a - alu_b;
      3'b010:  alu_y = alu_a & alu_b;
      3'b011:  alu_y = alu_a ^ alu_b;
      3'b100:  alu_y = alu_a | alu_b;
      3'b101:  alu_y = ~(alu_a & alu_b);
      3'b110:  alu_y = ~(alu_a | alu_b);
      default: alu_y = ~(alu_a ^ alu_b);
    endcase
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one command while idle; returns just after the accepting edge.
  task automatic applyStimulus(input logic ld, input logic [2:0] op,
                               input logic [1:0] dst, input logic [1:0] sa,
                               input logic [1:0] sb, input logic ie,
                               input logic [7:0] imm);
    cmd_load   = ld;
    cmd_op     = op;
    cmd_dst    = dst;
    cmd_src_a  = sa;
    cmd_src_b  = sb;
    cmd_imm_en = ie;
    cmd_imm    = imm;
    cmd_valid  = 1'b1;
    checkOutput("cmd_ready_before_accept", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid  = 1'b0;
  endtask

  // Looks at the ALU drive during the issue cycle.
  task automatic checkIssue(input string tag, input logic [2:0] op,
                            input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    checkOutput({tag, "_opcode"}, {29'd0, alu_opcode}, {29'd0, op});
    checkOutput({tag, "_alu_a"}, {24'd0, alu_a}, {24'd0, a});
    checkOutput({tag, "_alu_b"}, {24'd0, alu_b}, {24'd0, b});
    checkOutput({tag, "_no_early_valid"}, {31'd0, res_valid}, 32'd0);
    checkOutput({tag, "_busy_issue"}, {31'd0, busy}, 32'd1);
  endtask

  // Waits (bounded) for the result, checks it, then accepts it.
  task automatic getResult(input string tag, input logic [7:0] exp_data,
                           input logic [1:0] exp_dst, input logic exp_zero,
                           input logic exp_ovf);
    int cnt;
    cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      cnt = i;
      if (res_valid) break;
    end
    checkOutput({tag, "_latency"}, cnt, 32'd1);
    checkOutput({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
    checkOutput({tag, "_data"}, {24'd0, res_data}, {24'd0, exp_data});
    checkOutput({tag, "_dst"}, {30'd0, res_dst}, {30'd0, exp_dst});
    checkOutput({tag, "_zero"}, {31'd0, res_zero}, {31'd0, exp_zero});
    checkOutput({tag, "_cmd_ready_low"}, {31'd0, cmd_ready}, 32'd0);
    checkOutput({tag, "_alu_a_quiet"}, {24'd0, alu_a}, 32'd0);
`ifdef ALU_ISSUER_OVF_EN
    checkOutput({tag, "_ovf"}, {31'd0, res_ovf}, {31'd0, exp_ovf});
`else
    $display("[TB] result %s data=0x%0h (ovf would be %0b)", tag, res_data, exp_ovf);
`endif
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    checkOutput({tag, "_valid_drop"}, {31'd0, res_valid}, 32'd0);
    checkOutput({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  // Directed sequence.
  initial begin
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_load   = 1'b0;
    cmd_op     = 3'b000;
    cmd_dst    = 2'd0;
    cmd_src_a  = 2'd0;
    cmd_src_b  = 2'd0;
    cmd_imm_en = 1'b0;
    cmd_imm    = 8'h00;
    res_ready  = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("rst_res_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("rst_res_data", {24'd0, res_data}, 32'd0);
    checkOutput("rst_res_dst", {30'd0, res_dst}, 32'd0);
    checkOutput("rst_res_zero", {31'd0, res_zero}, 32'd0);
    checkOutput("rst_alu_opcode", {29'd0, alu_opcode}, 32'd0);
    checkOutput("rst_alu_a", {24'd0, alu_a}, 32'd0);
    checkOutput("rst_alu_b", {24'd0, alu_b}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Loads: result one cycle after accept.
    applyStimulus(1'b1, 3'b000, 2'd1, 2'd0, 2'd0, 1'b0, 8'h7F);
    getResult("load_r1", 8'h7F, 2'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'b000, 2'd2, 2'd0, 2'd0, 1'b0, 8'h01);
    getResult("load_r2", 8'h01, 2'd2, 1'b0, 1'b0);

    // r0 = r1 + r2 = 0x80, signed overflow.
    applyStimulus(1'b0, 3'b000, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00);
    checkIssue("add", 3'b000, 8'h7F, 8'h01);
    getResult("add", 8'h80, 2'd0, 1'b0, 1'b1);

    // r3 = 0, r3 = r3 - 1 wraps to 0xFF, then r3 ^ r3 = 0.
    applyStimulus(1'b1, 3'b000, 2'd3, 2'd0, 2'd0, 1'b0, 8'h00);
    getResult("load_r3", 8'h00, 2'd3, 1'b1, 1'b0);
    applyStimulus(1'b0, 3'b001, 2'd3, 2'd3, 2'd0, 1'b1, 8'h01);
    checkIssue("sub_imm", 3'b001, 8'h00, 8'h01);
    getResult("sub_imm", 8'hFF, 2'd3, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'b011, 2'd3, 2'd3, 2'd3, 1'b0, 8'h00);
    checkIssue("xor_self", 3'b011, 8'hFF, 8'hFF);
    getResult("xor_self", 8'h00, 2'd3, 1'b1, 1'b0);

    // Backpressure: r1 = r0 | 0x05 held for 5 cycles while a load waits.
    applyStimulus(1'b0, 3'b100, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05);
    checkIssue("bp_or", 3'b100, 8'h80, 8'h05);
    cmd_load   = 1'b1;
    cmd_dst    = 2'd2;
    cmd_imm_en = 1'b0;
    cmd_imm    = 8'h33;
    cmd_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_hold_valid", {31'd0, res_valid}, 32'd1);
      checkOutput("bp_hold_data", {24'd0, res_data}, 32'h85);
      checkOutput("bp_hold_dst", {30'd0, res_dst}, 32'd1);
      checkOutput("bp_hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checkOutput("bp_release_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("bp_release_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_load  = 1'b0;
    checkOutput("bp_late_load_valid", {31'd0, res_valid}, 32'd1);
    checkOutput("bp_late_load_data", {24'd0, res_data}, 32'h33);
    checkOutput("bp_late_load_dst", {30'd0, res_dst}, 32'd2);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    checkOutput("bp_late_load_done", {31'd0, busy}, 32'd0);

    // Dependency: r1 = r1 + 0x10 = 0x95, then r2 = r1 ^ r2 = 0x95 ^ 0x33.
    applyStimulus(1'b0, 3'b000, 2'd1, 2'd1, 2'd0, 1'b1, 8'h10);
    checkIssue("dep_add", 3'b000, 8'h85, 8'h10);
    getResult("dep_add", 8'h95, 2'd1, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'b011, 2'd2, 2'd1, 2'd2, 1'b0, 8'h00);
    checkIssue("dep_xor", 3'b011, 8'h95, 8'h33);
    getResult("dep_xor", 8'hA6, 2'd2, 1'b0, 1'b0);

    // Asynchronous reset in the middle of an issue cycle.
    applyStimulus(1'b0, 3'b000, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_alu_opcode", {29'd0, alu_opcode}, 32'd0);
    checkOutput("arst_alu_a", {24'd0, alu_a}, 32'd0);
    checkOutput("arst_alu_b", {24'd0, alu_b}, 32'd0);
    checkOutput("arst_busy", {31'd0, busy}, 32'd0);
    checkOutput("arst_res_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("arst_res_data", {24'd0, res_data}, 32'd0);
    checkOutput("arst_res_dst", {30'd0, res_dst}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("arst_no_result", {31'd0, res_valid}, 32'd0);
      checkOutput("arst_stay_idle", {31'd0, busy}, 32'd0);
    end
    // Register file must read back as zero.
    applyStimulus(1'b0, 3'b100, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00);
    checkIssue("arst_regs", 3'b100, 8'h00, 8'h00);
    getResult("arst_regs", 8'h00, 2'd0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
